// File: rtl/mem_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_if
// Purpose  : CPU-side request/acknowledge bus between the MIPS data port
//            and mem_bus_ctrl.
// Signals  : cpu_req, mem_w, cpu_address, cpu2bus  (CPU -> controller)
//            bus2cpu, cpu_ack, bus_err             (controller -> CPU)
// Modports : master = CPU side, slave = controller side
// Revision : 1.0 - initial release
// ============================================================================
interface mem_bus_if #(
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              mem_w;
    logic [31:0]       cpu_address;
    logic [DATA_W-1:0] cpu2bus;
    logic [DATA_W-1:0] bus2cpu;
    logic              cpu_ack;
    logic              bus_err;

    modport master (
        output cpu_req, mem_w, cpu_address, cpu2bus,
        input  bus2cpu, cpu_ack, bus_err
    );

    modport slave (
        input  cpu_req, mem_w, cpu_address, cpu2bus,
        output bus2cpu, cpu_ack, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_ctrl
// Purpose  : Registered, handshaked CPU memory bus. Decodes each access by
//            cpu_address[31:28] into data RAM, VRAM or unmapped, drives the
//            selected slave for a per-region number of cycles and returns a
//            one-cycle acknowledge (with bus_err for unmapped addresses).
// Ports    : clk, rst            - clock, synchronous active-high reset
//            cpu (mem_bus_if)    - CPU request/ack bus (slave modport)
//            ram_address/bus2ram/ram2bus/ram_w       - word-wide data RAM
//            vram_address/bus2vram/vram2bus/vram_w   - byte-wide VRAM
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int         DATA_W   = 32,
    parameter int         RAM_AW   = 12,
    parameter int         VRAM_AW  = 16,
    parameter int         VRAM_DW  = 8,
    parameter logic [3:0] RAM_SEL  = 4'h0,
    parameter logic [3:0] VRAM_SEL = 4'hF,
    parameter int         RAM_LAT  = 1,
    parameter int         VRAM_LAT = 2
) (
    input  wire logic                clk,
    input  wire logic                rst,
    mem_bus_if.slave                 cpu,
    output logic [RAM_AW-1:0]        ram_address,
    output logic [DATA_W-1:0]        bus2ram,
    input  wire logic [DATA_W-1:0]   ram2bus,
    output logic                     ram_w,
    output logic [VRAM_AW-1:0]       vram_address,
    output logic [VRAM_DW-1:0]       bus2vram,
    input  wire logic [VRAM_DW-1:0]  vram2bus,
    output logic                     vram_w
);

    localparam int MAX_LAT = (RAM_LAT > VRAM_LAT) ? RAM_LAT : VRAM_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    // Only the address bits either slave can see are kept in the latch.
    localparam int LATCH_W = (RAM_AW + 2 > VRAM_AW) ? RAM_AW + 2 : VRAM_AW;

    localparam logic [CNT_W-1:0] RAM_CNT_INIT  = CNT_W'(RAM_LAT - 1);
    localparam logic [CNT_W-1:0] VRAM_CNT_INIT = CNT_W'(VRAM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_RAM  = 2'd1,
        REG_VRAM = 2'd2
    } region_t;

    state_t              state, state_next;
    region_t             region, region_dec;
    logic [LATCH_W-1:0]  addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                write_q;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                accept, capture;
    logic                ack_q, ack_next;
    logic                err_q, err_next;
    logic                ram_w_next, vram_w_next;
    logic [DATA_W-1:0]   rdata_q, rdata_sel;

    // Upper address bits between the region field and the latch are
    // architecturally don't-care; fold them so they are visibly consumed.
    logic unused_addr;
    assign unused_addr = ^cpu.cpu_address;

    // RAM is tested first so it wins if both selects are equal.
    always_comb begin
        region_dec = REG_NONE;
        if (cpu.cpu_address[31:28] == RAM_SEL) begin
            region_dec = REG_RAM;
        end else if (cpu.cpu_address[31:28] == VRAM_SEL) begin
            region_dec = REG_VRAM;
        end
    end

    // Write accesses return zero; VRAM reads are zero-extended.
    always_comb begin
        rdata_sel = '0;
        if (!write_q) begin
            case (region)
                REG_RAM:  rdata_sel = ram2bus;
                REG_VRAM: rdata_sel = DATA_W'(vram2bus);
                default:  rdata_sel = '0;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        accept      = 1'b0;
        capture     = 1'b0;
        ack_next    = 1'b0;
        err_next    = 1'b0;
        ram_w_next  = 1'b0;
        vram_w_next = 1'b0;
        case (state)
            IDLE: begin
                if (cpu.cpu_req) begin
                    accept = 1'b1;
                    case (region_dec)
                        REG_RAM: begin
                            state_next = ACCESS;
                            cnt_next   = RAM_CNT_INIT;
                            ram_w_next = cpu.mem_w;
                        end
                        REG_VRAM: begin
                            state_next  = ACCESS;
                            cnt_next    = VRAM_CNT_INIT;
                            vram_w_next = cpu.mem_w;
                        end
                        default: begin
                            // Unmapped: skip straight to the acknowledge.
                            state_next = DONE;
                            cnt_next   = '0;
                            ack_next   = 1'b1;
                            err_next   = 1'b1;
                        end
                    endcase
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                    ack_next   = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            region  <= REG_NONE;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ram_w   <= 1'b0;
            vram_w  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            ack_q  <= ack_next;
            err_q  <= err_next;
            ram_w  <= ram_w_next;
            vram_w <= vram_w_next;
            if (accept) begin
                region  <= region_dec;
                addr_q  <= cpu.cpu_address[LATCH_W-1:0];
                data_q  <= cpu.cpu2bus;
                write_q <= cpu.mem_w;
                rdata_q <= '0;
            end
            if (capture) begin
                rdata_q <= rdata_sel;
            end
        end
    end

    assign cpu.cpu_ack = ack_q;
    assign cpu.bus_err = err_q;
    assign cpu.bus2cpu = rdata_q;

    // Slave address/data come straight from the latch registers.
    assign ram_address  = addr_q[RAM_AW+1:2];
    assign bus2ram      = data_q;
    assign vram_address = addr_q[VRAM_AW-1:0];
    assign bus2vram     = data_q[VRAM_DW-1:0];

endmodule
`default_nettype wire
